// File: rtl/sort_rd_arb.sv
// Two-requester AXI read-address arbiter: round-robin grant into a single registered AR slot,
// per-requester outstanding-burst credit, and combinational R-channel routing by rid.
module sort_rd_arb #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 1024,
  parameter int unsigned ARUSER_WIDTH    = 9,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [7:0]              s0_arlen,
  input  logic [ARUSER_WIDTH-1:0] s0_aruser,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [7:0]              s1_arlen,
  input  logic [ARUSER_WIDTH-1:0] s1_aruser,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rlast,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rlast,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic                    m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic                    m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    arb_idle
);

  localparam logic [3:0] MaxCnt = 4'(MAX_OUTSTANDING);

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e                   state_q, state_d;
  logic                    arid_q, arid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [ARUSER_WIDTH-1:0] aruser_q, aruser_d;
  // Index of the last granted requester; the other one wins the next tie.
  logic                    rr_q, rr_d;
  logic [3:0]              cnt_q [2];
  logic [3:0]              cnt_d [2];

  logic       slot_free;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       r_done;

  always_comb begin
    slot_free = (state_q == StEmpty) || m_axi_arready;
    elig[0]   = s0_arvalid && (cnt_q[0] < MaxCnt);
    elig[1]   = s1_arvalid && (cnt_q[1] < MaxCnt);
    grant     = 2'b00;
    if (rst_n && slot_free) begin
      if (elig[0] && (!elig[1] || rr_q)) begin
        grant[0] = 1'b1;
      end else if (elig[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    aruser_d = aruser_q;
    rr_d     = rr_q;
    if (grant != 2'b00) begin
      state_d  = StFull;
      arid_d   = grant[1];
      araddr_d = grant[1] ? s1_araddr : s0_araddr;
      arlen_d  = grant[1] ? s1_arlen  : s0_arlen;
      aruser_d = grant[1] ? s1_aruser : s0_aruser;
      rr_d     = grant[1];
    end else if (slot_free) begin
      state_d = StEmpty;
    end
  end

  assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic inc, dec;
      inc = grant[i];
      // A completion for an idle requester is forwarded but cannot underflow its count.
      dec = r_done && (m_axi_rid == 1'(i)) && (cnt_q[i] != 4'd0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      arid_q   <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      aruser_q <= '0;
      rr_q     <= 1'b1;
      cnt_q[0] <= 4'd0;
      cnt_q[1] <= 4'd0;
    end else begin
      state_q  <= state_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      aruser_q <= aruser_d;
      rr_q     <= rr_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign s0_arready    = grant[0];
  assign s1_arready    = grant[1];
  assign m_axi_arvalid = (state_q == StFull);
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_aruser  = aruser_q;

  assign s0_rvalid    = m_axi_rvalid && !m_axi_rid;
  assign s1_rvalid    = m_axi_rvalid && m_axi_rid;
  assign s0_rdata     = m_axi_rdata;
  assign s1_rdata     = m_axi_rdata;
  assign s0_rresp     = m_axi_rresp;
  assign s1_rresp     = m_axi_rresp;
  assign s0_rlast     = m_axi_rlast;
  assign s1_rlast     = m_axi_rlast;
  assign m_axi_rready = m_axi_rid ? s1_rready : s0_rready;

  assign arb_idle = (state_q == StEmpty) && (cnt_q[0] == 4'd0) && (cnt_q[1] == 4'd0);

endmodule

// File: tb/tb_sort_rd_arb.sv
// Directed self-checking bench for sort_rd_arb: reset, single grant, tie round-robin,
// AR backpressure, credit exhaustion, R routing and mid-operation reset.
module tb_sort_rd_arb;
  localparam int AW = 64;
  localparam int DW = 1024;
  localparam int UW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] s0_araddr, s1_araddr;
  logic [7:0]    s0_arlen, s1_arlen;
  logic [UW-1:0] s0_aruser, s1_aruser;
  logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp;
  logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic          m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [UW-1:0] m_axi_aruser;
  logic          m_axi_arvalid, m_axi_arready;
  logic          m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic          arb_idle;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sort_rd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_aruser(s0_aruser),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_aruser(s1_aruser),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .arb_idle(arb_idle)
  );

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    s0_araddr = '0; s0_arlen = '0; s0_aruser = '0; s0_arvalid = 1'b0;
    s1_araddr = '0; s1_arlen = '0; s1_aruser = '0; s1_arvalid = 1'b0;
    s0_rready = 1'b0; s1_rready = 1'b0;
    m_axi_arready = 1'b1;
    m_axi_rid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    s0_arvalid = 1'b1;
    s0_araddr  = 64'h55;
    @(negedge clk);
    n_cmp++; if (s0_arready !== 1'b0) begin n_err++;
      $display("FAIL reset_no_grant got=%b exp=0", s0_arready); end
    next_cycle();
    s0_arvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_err++;
      $display("FAIL reset_arvalid got=%b exp=0", m_axi_arvalid); end
    n_cmp++; if ({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_aruser} !== '0) begin n_err++;
      $display("FAIL reset_ar_fields got=%h/%h/%h/%h exp=0", m_axi_arid, m_axi_araddr,
               m_axi_arlen, m_axi_aruser); end
    n_cmp++; if (arb_idle !== 1'b1) begin n_err++;
      $display("FAIL reset_idle got=%b exp=1", arb_idle); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = 64'h1000; s0_arlen = 8'd0; s0_aruser = 9'h5;
    @(negedge clk);
    n_cmp++; if ({s0_arready, s1_arready} !== 2'b10) begin n_err++;
      $display("FAIL single_grant got=%b%b exp=10", s0_arready, s1_arready); end
    next_cycle();
    s0_arvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m_axi_arvalid, m_axi_arid} !== 2'b10) begin n_err++;
      $display("FAIL single_arvalid_id got=%b%b exp=10", m_axi_arvalid, m_axi_arid); end
    n_cmp++; if ({m_axi_araddr, m_axi_arlen, m_axi_aruser} !== {64'h1000, 8'd0, 9'h5}) begin
      n_err++; $display("FAIL single_fields got=%h/%h/%h exp=1000/0/5", m_axi_araddr,
                        m_axi_arlen, m_axi_aruser); end
    n_cmp++; if (s0_arready !== 1'b0) begin n_err++;
      $display("FAIL single_one_grant got=%b exp=0", s0_arready); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if ({m_axi_arvalid, arb_idle} !== 2'b00) begin n_err++;
      $display("FAIL single_outstanding got=%b%b exp=00", m_axi_arvalid, arb_idle); end
    next_cycle();
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 1'b0; s0_rready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s0_rvalid, s1_rvalid, m_axi_rready} !== 3'b101) begin n_err++;
      $display("FAIL single_rbeat got=%b%b%b exp=101", s0_rvalid, s1_rvalid, m_axi_rready); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (arb_idle !== 1'b1) begin n_err++;
      $display("FAIL single_idle_after got=%b exp=1", arb_idle); end
    next_cycle();
  endtask

  task automatic test_tie;
    logic exp_g;
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = 64'hA0;
    s1_arvalid = 1'b1; s1_araddr = 64'hB0;
    for (int k = 0; k < 4; k++) begin
      exp_g = 1'(k % 2);
      @(negedge clk);
      n_cmp++; if ({s0_arready, s1_arready} !== {~exp_g, exp_g}) begin n_err++;
        $display("FAIL tie_grant%0d got=%b%b exp=%b%b", k, s0_arready, s1_arready,
                 ~exp_g, exp_g); end
      if (k > 0) begin
        n_cmp++; if ({m_axi_arvalid, m_axi_arid} !== {1'b1, ~exp_g}) begin n_err++;
          $display("FAIL tie_arid%0d got=%b%b exp=1%b", k, m_axi_arvalid, m_axi_arid,
                   ~exp_g); end
        n_cmp++; if (m_axi_araddr !== (exp_g ? 64'hA0 : 64'hB0)) begin n_err++;
          $display("FAIL tie_addr%0d got=%h exp=%h", k, m_axi_araddr,
                   exp_g ? 64'hA0 : 64'hB0); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    m_axi_arready = 1'b0;
    s0_arvalid = 1'b1; s0_araddr = 64'h2000; s0_arlen = 8'd3;
    @(negedge clk);
    n_cmp++; if (s0_arready !== 1'b1) begin n_err++;
      $display("FAIL bp_first_grant got=%b exp=1", s0_arready); end
    next_cycle();
    s0_araddr = 64'h2040;
    s1_arvalid = 1'b1; s1_araddr = 64'h3000; s1_arlen = 8'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if ({m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen} !==
                   {1'b1, 1'b0, 64'h2000, 8'd3}) begin n_err++;
        $display("FAIL bp_hold%0d got=%b/%b/%h/%h exp=1/0/2000/03", k, m_axi_arvalid,
                 m_axi_arid, m_axi_araddr, m_axi_arlen); end
      n_cmp++; if ({s0_arready, s1_arready} !== 2'b00) begin n_err++;
        $display("FAIL bp_no_grant%0d got=%b%b exp=00", k, s0_arready, s1_arready); end
      next_cycle();
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s0_arready, s1_arready} !== 2'b01) begin n_err++;
      $display("FAIL bp_resume got=%b%b exp=01", s0_arready, s1_arready); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if ({m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen} !==
                 {1'b1, 1'b1, 64'h3000, 8'd7}) begin n_err++;
      $display("FAIL bp_next_slot got=%b/%b/%h/%h exp=1/1/3000/07", m_axi_arvalid,
               m_axi_arid, m_axi_araddr, m_axi_arlen); end
    next_cycle();
  endtask

  task automatic test_credit;
    do_reset();
    s1_arvalid = 1'b1; s1_araddr = 64'h4000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (s1_arready !== 1'b1) begin n_err++;
        $display("FAIL credit_s1_grant%0d got=%b exp=1", k, s1_arready); end
      next_cycle();
    end
    s0_arvalid = 1'b1; s0_araddr = 64'h5000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if ({s0_arready, s1_arready} !== 2'b10) begin n_err++;
        $display("FAIL credit_blocked%0d got=%b%b exp=10", k, s0_arready, s1_arready); end
      next_cycle();
    end
    s0_arvalid = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 1'b1; s1_rready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s1_arready, m_axi_rready} !== 2'b01) begin n_err++;
      $display("FAIL credit_rlast_cycle got=%b%b exp=01", s1_arready, m_axi_rready); end
    next_cycle();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rid = 1'b0; s1_rready = 1'b0;
    @(negedge clk);
    n_cmp++; if (s1_arready !== 1'b1) begin n_err++;
      $display("FAIL credit_returned got=%b exp=1", s1_arready); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_routing;
    logic [DW-1:0] exp_data;
    logic          rdy;
    int            beat;
    do_reset();
    beat = 0;
    m_axi_rid = 1'b1; m_axi_rresp = 2'd2; m_axi_rvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rdy = (k % 2 == 0);
      exp_data = {32{32'hC0DE_0000 + 32'(beat)}};
      s1_rready = rdy; s0_rready = ~rdy;
      m_axi_rdata = exp_data; m_axi_rlast = (beat == 3);
      @(negedge clk);
      n_cmp++; if ({s0_rvalid, s1_rvalid, m_axi_rready} !== {1'b0, 1'b1, rdy}) begin n_err++;
        $display("FAIL route_valid%0d got=%b%b%b exp=01%b", k, s0_rvalid, s1_rvalid,
                 m_axi_rready, rdy); end
      n_cmp++; if ({s1_rresp, s1_rlast} !== {2'd2, beat == 3}) begin n_err++;
        $display("FAIL route_resp_last%0d got=%0d/%b exp=2/%b", k, s1_rresp, s1_rlast,
                 beat == 3); end
      n_cmp++; if (s1_rdata !== exp_data) begin n_err++;
        $display("FAIL route_data%0d got=%h exp=%h", k, s1_rdata[31:0], exp_data[31:0]); end
      if (rdy) beat++;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (arb_idle !== 1'b1) begin n_err++;
      $display("FAIL route_saturate got=%b exp=1", arb_idle); end
    next_cycle();
  endtask

  task automatic test_reset_mid;
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = 64'h6000;
    s1_arvalid = 1'b1; s1_araddr = 64'h7000;
    for (int k = 0; k < 6; k++) next_cycle();
    s0_arvalid = 1'b0;
    next_cycle();
    next_cycle();
    s1_arvalid = 1'b0; m_axi_arready = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m_axi_arvalid, m_axi_arid, arb_idle} !== 3'b110) begin n_err++;
      $display("FAIL rmid_full got=%b%b%b exp=110", m_axi_arvalid, m_axi_arid, arb_idle); end
    next_cycle();
    rst_n = 1'b0; s0_arvalid = 1'b1; m_axi_arready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s0_arready, s1_arready} !== 2'b00) begin n_err++;
      $display("FAIL rmid_no_grant got=%b%b exp=00", s0_arready, s1_arready); end
    next_cycle();
    rst_n = 1'b1; s0_arvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({m_axi_arvalid, arb_idle, m_axi_araddr} !== {1'b0, 1'b1, 64'h0}) begin
      n_err++; $display("FAIL rmid_cleared got=%b/%b/%h exp=0/1/0", m_axi_arvalid, arb_idle,
                        m_axi_araddr); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_credit();
    test_routing();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
